// File: rtl/tt_sweep_chk.sv
// Exhaustive truth-table sweep: drives every N_IN-bit vector to N_CH implementations,
// compares their result bits against channel 0 and records the first disagreement.
module tt_sweep_chk #(
  parameter int N_IN  = 4,
  parameter int N_CH  = 3,
  parameter int DWELL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop_on_err,
  output logic [N_IN-1:0] vec_o,
  input  logic [N_CH-1:0] f_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec,
  output logic [N_CH-1:0] fail_mask
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      dwell_q, dwell_d;
  logic            stop_q, stop_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic [N_CH-1:0] fmask_q, fmask_d;

  logic [N_CH-1:0] diff_mask;
  logic            mismatch;

  // Every channel is judged against channel 0; any set bit means disagreement.
  assign diff_mask = f_i ^ {N_CH{f_i[0]}};
  assign mismatch  = |diff_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      dwell_q <= '0;
      stop_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fmask_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    stop_d  = stop_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          dwell_d = '0;
          stop_d  = stop_on_err;
          err_d   = '0;
          fvec_d  = '0;
          fmask_d = '0;
        end
      end
      S_DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          state_d = S_SAMPLE;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + {{N_IN{1'b0}}, 1'b1};
          if (err_q == '0) begin
            fvec_d  = vec_q;
            fmask_d = diff_mask;
          end
        end
        // The all-ones vector is the last one; the sweep never wraps.
        if ((&vec_q) || (mismatch && stop_q)) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vec_o     = vec_q;
  assign busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == '0);
  assign err_cnt   = err_q;
  assign fail_vec  = fvec_q;
  assign fail_mask = fmask_q;

endmodule
